// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative RV32M divider.
// Operation encoding matches the funct3[1:0] ordering of DIV/DIVU/REM/REMU.
package div_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } div_state_e;

    function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] x);
        return ~x + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic op_is_signed(input div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/full_adder_32_bit.sv
// 32-bit ripple-carry adder; the divider uses it as its trial subtractor
// by feeding the inverted divisor with cin=1.
module full_adder_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    always_comb begin
        logic c;
        sum = '0;
        c   = cin;
        for (int unsigned i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/div_unit_32.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per
// cycle through a shared 32-bit ripple subtractor, start/ready/valid handshake.
import div_pkg::*;

module div_unit_32 #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    div_state_e      state, state_nx;
    div_op_e         op_q;
    logic            q_neg, r_neg;
    logic            pend;
    logic [4:0]      count;
    logic [XLEN-1:0] quo, rem, dvs;

    // Accept-time decode of the incoming operands
    div_op_e         in_op;
    logic            in_signed, a_neg, b_neg;
    logic            div_zero, ovf;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        in_op     = div_op_e'(i_op);
        in_signed = op_is_signed(in_op);
        a_neg     = in_signed & i_dividend[XLEN-1];
        b_neg     = in_signed & i_divisor[XLEN-1];
        a_mag     = a_neg ? neg32(i_dividend) : i_dividend;
        b_mag     = b_neg ? neg32(i_divisor) : i_divisor;
        div_zero  = (i_divisor == '0);
        ovf       = in_signed && (i_dividend == {1'b1, {(XLEN-1){1'b0}}})
                              && (i_divisor == '1);
    end

    // One restoring step: rem[31] shifted out means the trial always fits
    logic [XLEN-1:0] shifted, diff;
    logic            carry_out, cout, take;

    assign shifted   = {rem[XLEN-2:0], quo[XLEN-1]};
    assign carry_out = rem[XLEN-1];

    full_adder_32_bit u_trial_sub (
        .a    (shifted),
        .b    (~dvs),
        .cin  (1'b1),
        .sum  (diff),
        .cout (cout)
    );

    assign take = carry_out | cout;

    logic [XLEN-1:0] quo_fix, rem_fix, final_result;

    always_comb begin
        quo_fix      = q_neg ? neg32(quo) : quo;
        rem_fix      = r_neg ? neg32(rem) : rem;
        final_result = op_is_rem(op_q) ? rem_fix : quo_fix;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_start) state_nx = RUN;
            RUN:     if (pend) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        o_ready = (state == IDLE);
        o_valid = (state == DONE);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Special cases preload quo/rem with the answer and set pend, so the single
    // RUN cycle that follows only applies sign correction and registers it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            op_q     <= DIV;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            pend     <= 1'b0;
            count    <= '0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            o_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        op_q  <= in_op;
                        r_neg <= a_neg;
                        count <= '0;
                        dvs   <= b_mag;
                        if (div_zero) begin
                            quo   <= '1;
                            rem   <= a_mag;
                            q_neg <= 1'b0;
                            pend  <= 1'b1;
                        end else if (ovf) begin
                            quo   <= {1'b1, {(XLEN-1){1'b0}}};
                            rem   <= '0;
                            q_neg <= 1'b0;
                            pend  <= 1'b1;
                        end else begin
                            quo   <= a_mag;
                            rem   <= '0;
                            q_neg <= a_neg ^ b_neg;
                            pend  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (pend) begin
                        o_result <= final_result;
                        pend     <= 1'b0;
                    end else begin
                        rem   <= take ? diff : shifted;
                        quo   <= {quo[XLEN-2:0], take};
                        count <= count + 5'd1;
                        if (count == 5'(ITERS - 1)) pend <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
